// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator: pixel divider, x/y counters, registered syncs
// Define VGA_SYNC_FRAME_TICK_EN to build the frame_tick strobe; otherwise frame_tick is tied low.
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISP);
  localparam logic [9:0] V_VIS  = 10'(V_DISP);
  // Sync windows use inclusive bounds so a window ending at 1023 still fits 10 bits.
  localparam logic [9:0] HS_BEG = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END = 10'(V_DISP + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;

  always_comb begin
    tick   = (div_q == DIV_LAST);
    div_d  = tick ? '0 : div_q + DIV_W'(1);
    h_wrap = tick && (x_q == H_LAST);
    v_wrap = h_wrap && (y_q == V_LAST);

    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      x_d = h_wrap ? '0 : x_q + 10'd1;
    end
    if (h_wrap) begin
      y_d = v_wrap ? '0 : y_q + 10'd1;
    end

    // Decoded from next-state counters so the registered flags line up with pix_x/pix_y.
    video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
    hsync_d    = !((x_d >= HS_BEG) && (x_d <= HS_END));
    vsync_d    = !((y_d >= VS_BEG) && (y_d <= VS_END));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      video_on_q <= 1'b1;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      div_q      <= div_d;
      x_q        <= x_d;
      y_q        <= y_d;
      video_on_q <= video_on_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign p_tick   = tick;
  assign pix_x    = x_q;
  assign pix_y    = y_q;
  assign video_on = video_on_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;

`ifdef VGA_SYNC_FRAME_TICK_EN
  logic frame_tick_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= v_wrap;
    end
  end

  assign frame_tick = frame_tick_q;
`else
  assign frame_tick = 1'b0;
`endif

endmodule
